// File: rtl/branch_resolve_redirect.sv
// ============================================================================
// Module   : branch_resolve_redirect
// Brief    : Branch resolution consumer: mispredict recovery (flush, then
//            redirect) plus a predictor-training update FIFO toward fetch.
//            Optional statistics counters enabled by defining BRU_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_resolve_redirect #(
    parameter int SIZE_PC      = 32,
    parameter int SIZE_AGE     = 6,
    parameter int UPD_DEPTH    = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                exeValid_i,
    input  logic [SIZE_PC-1:0]  exePC_i,
    input  logic [SIZE_PC-1:0]  exeNextPC_i,
    input  logic                exeDir_i,
    input  logic [7:0]          exeFlags_i,
    input  logic [SIZE_AGE-1:0] exeAge_i,
    input  logic [SIZE_AGE-1:0] headAge_i,
    input  logic                bpUpdReady_i,
    output logic                flush_o,
    output logic [SIZE_AGE-1:0] recoverAge_o,
    output logic                redirectValid_o,
    output logic [SIZE_PC-1:0]  redirectPC_o,
    output logic                fetchStall_o,
    output logic                bpUpdValid_o,
    output logic [SIZE_PC-1:0]  bpUpdPC_o,
    output logic [SIZE_PC-1:0]  bpUpdTarget_o,
    output logic                bpUpdDir_o,
    output logic [15:0]         mispredCnt_o,
    output logic [15:0]         updDropCnt_o
);

    localparam int c_AW     = $clog2(UPD_DEPTH);
    localparam int c_CNT_W  = $clog2(FLUSH_CYCLES + 1);
    localparam int c_ENT_W  = 2 * SIZE_PC + 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(FLUSH_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_FLUSH    = 2'd1,
        S_REDIRECT = 2'd2
    } state_t;

    state_t               r_state, w_state_nx;
    logic [c_CNT_W-1:0]   r_cnt, w_cnt_nx;
    logic [SIZE_AGE-1:0]  r_age, w_age_nx;
    logic [SIZE_PC-1:0]   r_pc, w_pc_nx;
    logic                 w_flush, w_redirect, w_stall;

    // Ages are compared by distance from the oldest in-flight instruction.
    logic [SIZE_AGE-1:0]  w_dist_exe, w_dist_lat;
    logic                 w_mispred, w_accept, w_squash;

    assign w_dist_exe = exeAge_i - headAge_i;
    assign w_dist_lat = r_age - headAge_i;
    assign w_mispred  = exeValid_i & exeFlags_i[0];
    assign w_accept   = w_mispred & ((r_state == S_IDLE) | (w_dist_exe < w_dist_lat));
    assign w_squash   = (r_state != S_IDLE) & (w_dist_exe > w_dist_lat);

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_age_nx   = r_age;
        w_pc_nx    = r_pc;
        w_flush    = 1'b0;
        w_redirect = 1'b0;
        w_stall    = 1'b0;
        case (r_state)
            S_FLUSH: begin
                w_flush = 1'b1;
                w_stall = 1'b1;
                if (r_cnt == c_CNT_ONE) begin
                    w_state_nx = S_REDIRECT;
                end else begin
                    w_cnt_nx = r_cnt - c_CNT_ONE;
                end
            end
            S_REDIRECT: begin
                w_redirect = 1'b1;
                w_stall    = 1'b1;
                w_state_nx = S_IDLE;
            end
            default: ;
        endcase
        // An older mispredict always wins and restarts the full flush window.
        if (w_accept) begin
            w_state_nx = S_FLUSH;
            w_cnt_nx   = c_CNT_LOAD;
            w_age_nx   = exeAge_i;
            w_pc_nx    = exeNextPC_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_age   <= '0;
            r_pc    <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_age   <= w_age_nx;
            r_pc    <= w_pc_nx;
        end
    end

    assign flush_o         = w_flush;
    assign redirectValid_o = w_redirect;
    assign fetchStall_o    = w_stall;
    assign recoverAge_o    = r_age;
    assign redirectPC_o    = r_pc;

    // Update FIFO: pointers carry one extra bit to tell full from empty.
    logic [c_ENT_W-1:0] r_mem [UPD_DEPTH];
    logic [c_AW:0]      r_wr_ptr, r_rd_ptr, w_wr_nx, w_rd_nx;
    logic [c_ENT_W-1:0] r_head, w_wdata, w_head_src;
    logic               r_upd_valid;
    logic               w_push_req, w_push, w_pop, w_full, w_drop;

    assign w_push_req = exeValid_i & exeFlags_i[5] & ~w_squash;
    assign w_pop      = r_upd_valid & bpUpdReady_i;
    assign w_full     = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                        (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign w_push     = w_push_req & (~w_full | w_pop);
    assign w_drop     = w_push_req & w_full & ~w_pop;
    assign w_wdata    = {exePC_i, exeNextPC_i, (exeFlags_i[2] ? exeDir_i : 1'b1)};
    assign w_wr_nx    = r_wr_ptr + {{c_AW{1'b0}}, w_push};
    assign w_rd_nx    = r_rd_ptr + {{c_AW{1'b0}}, w_pop};
    // When the FIFO drains to the slot being written, the new head is the write data.
    assign w_head_src = (w_rd_nx == r_wr_ptr) ? w_wdata : r_mem[w_rd_nx[c_AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= w_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_upd_valid <= 1'b0;
            r_head      <= '0;
        end else begin
            r_wr_ptr    <= w_wr_nx;
            r_rd_ptr    <= w_rd_nx;
            r_upd_valid <= (w_rd_nx != w_wr_nx);
            if (w_rd_nx != w_wr_nx) begin
                r_head <= w_head_src;
            end
        end
    end

    assign bpUpdValid_o  = r_upd_valid;
    assign bpUpdPC_o     = r_head[c_ENT_W-1 -: SIZE_PC];
    assign bpUpdTarget_o = r_head[SIZE_PC:1];
    assign bpUpdDir_o    = r_head[0];

`ifdef BRU_STATS_EN
    logic [15:0] r_mispred_cnt, r_drop_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mispred_cnt <= '0;
            r_drop_cnt    <= '0;
        end else begin
            if (w_accept && (r_mispred_cnt != 16'hFFFF)) begin
                r_mispred_cnt <= r_mispred_cnt + 16'd1;
            end
            if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end

    assign mispredCnt_o = r_mispred_cnt;
    assign updDropCnt_o = r_drop_cnt;
`else
    logic w_unused_stats;
    assign w_unused_stats = w_drop;
    assign mispredCnt_o   = 16'd0;
    assign updDropCnt_o   = 16'd0;
`endif

    logic w_unused_flags;
    assign w_unused_flags = ^{exeFlags_i[7:6], exeFlags_i[4:3], exeFlags_i[1]};

endmodule

`default_nettype wire

// File: doc/branch_resolve_redirect.md
Name: branch_resolve_redirect

Overview:
- Consumer side of the control-ALU result interface. Takes resolved control instructions (pc, nextPC, direction, flags, age) from execute.
- Runs a recovery FSM. On the oldest mispredict it drives a pipeline flush and then a fetch redirect.
- Buffers branch-predictor/BTB training updates in a small FIFO with a valid/ready handshake toward fetch.

Parameters:
- SIZE_PC, 32, PC/target width
- SIZE_AGE, 6, instruction age tag width (modulo wrap)
- UPD_DEPTH, 4, predictor-update FIFO entries (power of 2, >=2)
- FLUSH_CYCLES, 2, cycles flush_o is held before redirect (>=1)

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- exeValid_i  in  1  execute result valid this cycle
- exePC_i  in  SIZE_PC  PC of resolved instruction
- exeNextPC_i  in  SIZE_PC  resolved next PC
- exeDir_i  in  1  resolved direction
- exeFlags_i  in  8  bit0 mispredict, bit2 conditional/indirect (train direction), bit5 control instruction
- exeAge_i  in  SIZE_AGE  age tag of resolved instruction
- headAge_i  in  SIZE_AGE  age of oldest in-flight instruction (age reference)
- bpUpdReady_i  in  1  predictor accepts update
- flush_o  out  1  squash all instructions younger than recoverAge_o
- recoverAge_o  out  SIZE_AGE  age of mispredicting instruction
- redirectValid_o  out  1  one-cycle fetch redirect strobe
- redirectPC_o  out  SIZE_PC  fetch restart PC
- fetchStall_o  out  1  fetch must not issue
- bpUpdValid_o  out  1  FIFO head valid
- bpUpdPC_o  out  SIZE_PC  head PC
- bpUpdTarget_o  out  SIZE_PC  head target (resolved nextPC)
- bpUpdDir_o  out  1  head direction (forced 1 when bit2 clear)
- mispredCnt_o  out  16  mispredict count (optional feature)
- updDropCnt_o  out  16  dropped-update count (optional feature)

Behaviour:
- Reset (async, on posedge reset):
  - FSM enters IDLE.
  - FIFO is emptied.
  - All outputs are 0.
  - Counters are 0.
- Age order: dist(a) = (a - headAge_i) mod 2^SIZE_AGE. Smaller dist is older. Equal dist means the same instruction.
- A mispredict event is exeValid_i & exeFlags_i[0].
- FSM states IDLE, FLUSH, REDIRECT. All transitions are registered.
  - IDLE: on a mispredict event, latch age and exeNextPC_i, load counter = FLUSH_CYCLES, go to FLUSH.
  - FLUSH: flush_o=1 and fetchStall_o=1. Counter decrements each cycle. When it reaches 1, go to REDIRECT.
  - REDIRECT: redirectValid_o=1 and fetchStall_o=1 for exactly one cycle, redirectPC_o = latched PC. Then go to IDLE.
- Mispredict during FLUSH or REDIRECT:
  - Strictly older than the latched age: replace the latched age and PC, reload the counter, enter or remain in FLUSH.
  - Same age or younger: ignore it.
- Latency: a mispredict at cycle N gives flush_o in cycles N+1 .. N+FLUSH_CYCLES and redirectValid_o in cycle N+FLUSH_CYCLES+1.
- FIFO push condition: exeValid_i & exeFlags_i[5] & not squashed.
  - Squashed means the FSM is not IDLE and the instruction is younger than the latched age.
  - The mispredicting instruction itself is pushed.
- FIFO pop: bpUpdValid_o & bpUpdReady_i. Outputs are driven from the registered head.
- Full FIFO:
  - A push with no pop in the same cycle is dropped and updDropCnt_o is incremented.
  - Push and pop in the same cycle while full both succeed; occupancy is unchanged.
- Empty FIFO: bpUpdValid_o=0 and head data holds its last value. A push into an empty FIFO becomes visible the next cycle. There is no fall-through.
- Read and write pointers wrap modulo UPD_DEPTH. Occupancy is tracked with an extra pointer bit.
- Reset asserted mid-recovery aborts the FSM and the FIFO immediately.

Optional Feature:
- BRU_STATS_EN defined:
  - mispredCnt_o increments on every accepted mispredict event, including replacements. Ignored events do not count.
  - updDropCnt_o increments per dropped update.
  - Both counters saturate at 0xFFFF.
- BRU_STATS_EN undefined: both ports are tied to 0 and no counter flops are present.

Test Plan:
1. FLUSH_CYCLES=2. Mispredict in cycle 5, age 3, nextPC 0x400120. Expected: flush_o=1 in cycles 6-7; redirectValid_o=1 in cycle 8 with redirectPC_o=0x400120; fetchStall_o low from cycle 9.
2. headAge_i=60. Mispredict age 62 (PC 0xA0), then in the next cycle mispredict age 1 (dist 5, younger). Expected: age 1 ignored; redirect to 0xA0. Repeat with age 61: redirect is to its PC and the flush restarts for 2 full cycles.
3. UPD_DEPTH=4, bpUpdReady_i=0, six control pushes. Expected: 4 stored, updDropCnt_o=2. Then ready=1: updates drain in push order, one per cycle.
4. FIFO full with bpUpdReady_i=1 and a simultaneous push. Expected: push accepted, occupancy stays 4, drop count unchanged.
5. During FLUSH for age 10, a control push at age 12 (younger) and one at age 10. Expected: only the age-10 update enters the FIFO. JR with flags bit2=0 gives bpUpdDir_o=1.
6. Assert reset in the middle of FLUSH with 3 FIFO entries. Expected: flush_o, bpUpdValid_o and the counters go to 0 without waiting for a clock edge; after release the FSM is in IDLE.
